// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the dynamic branch predictor (BTB + PHT).
package bp_pkg;

   localparam int unsigned BP_PC_MAX_W  = 64;
   localparam int unsigned BP_CNT_MAX_W = 4;

   typedef enum {BP_STATIC, BP_BIMODAL, BP_GSHARE} bp_mode_e;

   // Tag and target are held at the widest supported PC and zero-extended.
   typedef struct packed {
      logic                   valid;
      logic [BP_PC_MAX_W-1:0] tag;
      logic [BP_PC_MAX_W-1:0] target;
   } btb_entry_t;

   // Saturating up/down step of a cnt_w-bit counter carried in a max-width container.
   function automatic logic [BP_CNT_MAX_W-1:0] sat_update(
      input logic [BP_CNT_MAX_W-1:0] cnt,
      input logic                    taken,
      input int unsigned             cnt_w
   );
      logic [BP_CNT_MAX_W-1:0] max_v;
      max_v = BP_CNT_MAX_W'((32'd1 << cnt_w) - 32'd1);
      if (taken) begin
         return (cnt == max_v) ? cnt : cnt + BP_CNT_MAX_W'(1);
      end
      return (cnt == '0) ? cnt : cnt - BP_CNT_MAX_W'(1);
   endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup and resolution-update bundle between the pipeline and the predictor.
interface branch_predictor_if #(
   parameter int unsigned PC_W  = 32,
   parameter int unsigned IDX_W = 6
);
   logic [PC_W-1:0]  if_pc;
   logic             pred_taken;
   logic [PC_W-1:0]  pred_target;
   logic [IDX_W-1:0] pred_idx;
   logic             upd_valid;
   logic [PC_W-1:0]  upd_pc;
   logic [IDX_W-1:0] upd_idx;
   logic             upd_pred_taken;
   logic             upd_taken;
   logic [PC_W-1:0]  upd_target;
   logic             redirect;
   logic [PC_W-1:0]  redirect_pc;
   logic [15:0]      mispred_cnt;

   modport master (
      output if_pc, upd_valid, upd_pc, upd_idx, upd_pred_taken, upd_taken, upd_target,
      input  pred_taken, pred_target, pred_idx, redirect, redirect_pc, mispred_cnt
   );

   modport slave (
      input  if_pc, upd_valid, upd_pc, upd_idx, upd_pred_taken, upd_taken, upd_target,
      output pred_taken, pred_target, pred_idx, redirect, redirect_pc, mispred_cnt
   );
endinterface

// File: rtl/branch_predictor_sat_counter_table.sv
// Pattern history table: ENTRIES saturating counters, async read, sync write,
// reset to weakly not-taken.
module sat_counter_table
   import bp_pkg::*;
#(
   parameter  int unsigned ENTRIES = 64,
   parameter  int unsigned CNT_W   = 2,
   localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx_i,
   output logic [CNT_W-1:0] rd_cnt_c_o,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  logic             wr_taken_i
);

   // Weakly not-taken; collapses to 0 for a single-bit counter.
   localparam logic [CNT_W-1:0] CNT_RST = CNT_W'((32'd1 << (CNT_W - 1)) - 32'd1);

   logic [CNT_W-1:0] cnt_q [ENTRIES];
   logic [CNT_W-1:0] cnt_d [ENTRIES];

   assign rd_cnt_c_o = cnt_q[rd_idx_i];

   always_comb begin
      cnt_d = cnt_q;
      if (wr_en_i) begin
         cnt_d[wr_idx_i] = CNT_W'(sat_update(BP_CNT_MAX_W'(cnt_q[wr_idx_i]), wr_taken_i, CNT_W));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            cnt_q[i] <= CNT_RST;
         end
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB plus saturating-counter PHT with static, bimodal and gshare
// modes; combinational fetch lookup, non-speculative update at resolution.
module branch_predictor
   import bp_pkg::*;
#(
   parameter int unsigned ENTRIES = 64,
   parameter int unsigned CNT_W   = 2,
   parameter int unsigned MODE    = 1,
   parameter int unsigned PC_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   branch_predictor_if.slave bus
);

   localparam int unsigned IDX_W  = $clog2(ENTRIES);
   localparam bp_mode_e    MODE_E = bp_mode_e'(MODE);

   btb_entry_t             btb_q [ENTRIES];
   btb_entry_t             btb_d [ENTRIES];
   logic [IDX_W-1:0]       ghr_q;
   logic [IDX_W-1:0]       ghr_d;
   logic [15:0]            mispred_cnt_q;
   logic [15:0]            mispred_cnt_d;

   logic [IDX_W-1:0]       lk_btb_idx_c;
   logic [IDX_W-1:0]       lk_pht_idx_c;
   logic [BP_PC_MAX_W-1:0] lk_tag_c;
   btb_entry_t             lk_entry_c;
   logic                   lk_hit_c;
   logic [CNT_W-1:0]       lk_cnt_c;

   logic [IDX_W-1:0]       up_btb_idx_c;
   logic [BP_PC_MAX_W-1:0] up_tag_c;
   btb_entry_t             up_entry_c;
   logic                   up_hit_c;
   logic                   tgt_miss_c;
   logic                   redirect_c;
   logic                   unused_c;

   // Fetch-side lookup; reads pre-update state so a same-cycle update is not seen.
   always_comb begin
      lk_btb_idx_c = bus.if_pc[IDX_W+1:2];
      lk_tag_c     = BP_PC_MAX_W'(bus.if_pc[PC_W-1:IDX_W+2]);
      lk_entry_c   = btb_q[lk_btb_idx_c];
      lk_hit_c     = lk_entry_c.valid && (lk_entry_c.tag == lk_tag_c);
      if (MODE_E == BP_GSHARE) begin
         lk_pht_idx_c = lk_btb_idx_c ^ ghr_q;
      end else if (MODE_E == BP_BIMODAL) begin
         lk_pht_idx_c = lk_btb_idx_c;
      end else begin
         lk_pht_idx_c = '0;
      end
   end

   sat_counter_table #(
      .ENTRIES (ENTRIES),
      .CNT_W   (CNT_W)
   ) u_pht (
      .clk        (clk),
      .rst        (rst),
      .rd_idx_i   (lk_pht_idx_c),
      .rd_cnt_c_o (lk_cnt_c),
      .wr_en_i    (bus.upd_valid),
      .wr_idx_i   (bus.upd_idx),
      .wr_taken_i (bus.upd_taken)
   );

   assign bus.pred_taken  = (MODE_E != BP_STATIC) && lk_hit_c && lk_cnt_c[CNT_W-1];
   assign bus.pred_target = PC_W'(lk_entry_c.target);
   assign bus.pred_idx    = lk_pht_idx_c;

   // A taken-taken resolution still mispredicts if the BTB no longer holds this
   // branch or holds a different target.
   always_comb begin
      up_btb_idx_c = bus.upd_pc[IDX_W+1:2];
      up_tag_c     = BP_PC_MAX_W'(bus.upd_pc[PC_W-1:IDX_W+2]);
      up_entry_c   = btb_q[up_btb_idx_c];
      up_hit_c     = up_entry_c.valid && (up_entry_c.tag == up_tag_c);
      tgt_miss_c   = !up_hit_c || (up_entry_c.target != BP_PC_MAX_W'(bus.upd_target));
      redirect_c   = bus.upd_valid &&
                     ((bus.upd_pred_taken != bus.upd_taken) ||
                      (bus.upd_taken && bus.upd_pred_taken && tgt_miss_c));
   end

   assign bus.redirect    = redirect_c;
   assign bus.redirect_pc = !bus.upd_valid ? '0 :
                            bus.upd_taken  ? bus.upd_target : bus.upd_pc + PC_W'(4);
   assign bus.mispred_cnt = mispred_cnt_q;

   assign unused_c = ^{bus.if_pc[1:0], lk_entry_c};

   always_comb begin
      btb_d         = btb_q;
      ghr_d         = ghr_q;
      mispred_cnt_d = mispred_cnt_q;
      if (bus.upd_valid) begin
         if (bus.upd_taken) begin
            btb_d[up_btb_idx_c] = '{valid:  1'b1,
                                    tag:    up_tag_c,
                                    target: BP_PC_MAX_W'(bus.upd_target)};
         end
         ghr_d = {ghr_q[IDX_W-2:0], bus.upd_taken};
         if (redirect_c && (mispred_cnt_q != 16'hFFFF)) begin
            mispred_cnt_d = mispred_cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            btb_q[i] <= '0;
         end
         ghr_q         <= '0;
         mispred_cnt_q <= '0;
      end else begin
         btb_q         <= btb_d;
         ghr_q         <= ghr_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the pipelined MIPS core. It replaces fixed predict-not-taken with a direct-mapped branch target buffer (BTB) and saturating-counter pattern history table (PHT). It offers static, bimodal and gshare modes. Fetch reads it every cycle with the IF-stage PC, and branch resolution in ID writes it back, raising a redirect on misprediction.

## Interface
Parameters:
- `ENTRIES`, 64: BTB/PHT depth; power of two, 4..1024; `IDX_W = log2(ENTRIES)`.
- `CNT_W`, 2: PHT counter width, 1..4.
- `MODE`, 1: 0 = static not-taken, 1 = bimodal, 2 = gshare.
- `PC_W`, 32: PC width.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: synchronous, active-low reset.
- `if_pc`  in  PC_W: fetch PC.
- `pred_taken`  out  1: predict taken.
- `pred_target`  out  PC_W: predicted target; valid when `pred_taken`.
- `pred_idx`  out  IDX_W: PHT index used; carried down the pipe.
- `upd_valid`  in  1: resolved branch this cycle.
- `upd_pc`  in  PC_W: PC of resolved branch.
- `upd_idx`  in  IDX_W: `pred_idx` captured at fetch.
- `upd_pred_taken`  in  1: prediction made at fetch.
- `upd_taken`  in  1: actual outcome.
- `upd_target`  in  PC_W: actual target.
- `redirect`  out  1: misprediction; flush IF.
- `redirect_pc`  out  PC_W: `upd_target` if taken, else `upd_pc+4`.
- `mispred_cnt`  out  16: saturating misprediction count.

## Operation
- BTB index is `pc[IDX_W+1:2]`. The tag is `pc[PC_W-1:IDX_W+2]`. Each entry holds a valid bit, the tag and the target.
- PHT index:
  - MODE 1: BTB index.
  - MODE 2: BTB index XOR `ghr`.
  - MODE 0: unused, driven 0.
- `ghr` is an IDX_W-bit register. It is updated non-speculatively at resolution: `{ghr[IDX_W-2:0], upd_taken}`.
- Lookup is combinational.
  - `pred_taken = hit && counter MSB`, where `hit` means the entry is valid and the tag matches.
  - In MODE 0, `pred_taken` is always 0.
- `redirect = upd_valid && (upd_pred_taken != upd_taken || (upd_taken && upd_pred_taken && BTB target at upd_pc != upd_target))`. It is combinational from the update inputs.
- On `upd_valid`, the following are registered at the next clock edge:
  - Counter at `upd_idx`: saturating increment if taken, else saturating decrement. Never wraps past 0 or `2^CNT_W-1`.
  - BTB entry at `upd_pc`: when taken, written with valid=1, tag and `upd_target`. When not taken, the entry is left unchanged.
  - `ghr` shifts.
  - `mispred_cnt` increments when `redirect`, saturating at 0xFFFF.

## Timing
- Prediction has zero-cycle latency from `if_pc`. Update takes effect one cycle after `upd_valid`.
- When a lookup and an update hit the same index in the same cycle, the lookup returns the pre-update contents (read-old).
- Reset is synchronous and active-low. While `rst`=0 at an edge:
  - All valid bits clear.
  - All counters go to `2^(CNT_W-1)-1` (weakly not-taken).
  - `ghr` and `mispred_cnt` go to 0.
  - Update inputs are ignored.
  - From the first cycle after reset, `pred_taken`=0 for every PC.
- An update presented during reset is lost. The pipeline flush on reset makes this benign.
- `redirect` and `redirect_pc` are 0 when `upd_valid`=0.
- With `CNT_W`=1, the counter is a single last-outcome bit and its reset value is 0.

## Structure
- Package `bp_pkg` holds `typedef enum {BP_STATIC, BP_BIMODAL, BP_GSHARE} bp_mode_e`. It also holds the `btb_entry_t` struct (valid, tag, target) and the function `sat_update(cnt, taken)`.
- One sub-module, `sat_counter_table`: ENTRIES×CNT_W counter array with one combinational read port, one synchronous write port and reset initialisation. The BTB and GHR live in the top level.

## Test plan
- **Reset.** Pulse `rst`=0 for 1 cycle. Then sweep `if_pc` 0x0..0xFC. Required: `pred_taken`=0 everywhere and `mispred_cnt`=0.
- **Bimodal training.** ENTRIES=64, CNT_W=2. Resolve taken branch pc=0x40, target 0x100, three times. Required:
  - 1st update: `redirect`=1, `redirect_pc`=0x100.
  - Counter goes 1→2→3→3 (saturates).
  - From cycle after 1st update: `if_pc`=0x40 gives `pred_taken`=1, `pred_target`=0x100.
- **Not-taken recovery.** From state 3, resolve pc=0x40 not-taken twice. Required:
  - 1st: `redirect`=1, `redirect_pc`=0x44, prediction still taken (state 2).
  - 2nd: state 1, prediction not-taken.
- **Aliasing/tag.** Train 0x40 taken, then look up 0x140 (same index, different tag). Required: `pred_taken`=0.
- **Same-cycle collision.** `if_pc`=0x40 with an update to 0x40 in the same cycle. Required: old prediction this cycle, new prediction next cycle.
- **Gshare and saturation.** MODE=2, alternating T/N branch at 0x80. Required: after warm-up, zero further redirects. Also force 70000 mispredicts and check `mispred_cnt` holds at 0xFFFF.
